// File: rtl/frame_readout_ctrl.sv
// Frame readout controller: walks a held frame byte by byte through an external
// data multiplexer and hands each byte to the host with a valid/ready handshake.
module frame_readout_ctrl #(
    parameter int NUM_BYTES = 12,
    parameter int ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              full,
    input  logic [7:0]        parallel_in,
    output logic [ADDR_W-1:0] address,
    output logic              rx_enable,
    output logic              rx_clear,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              frame_done,
    output logic [7:0]        overrun_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PRESENT  = 3'd2,
        RELEASE  = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic              full_prev_r;
    logic              full_rise_s;
    logic [ADDR_W-1:0] address_next_s;
    logic              rx_enable_next_s;
    logic              rx_clear_next_s;
    logic [7:0]        byte_data_next_s;
    logic              byte_valid_next_s;
    logic              byte_last_next_s;
    logic              frame_done_next_s;

    assign full_rise_s = full & ~full_prev_r;

    // State register and previous-full sampler for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            full_prev_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            full_prev_r <= full;
        end
    end

    // Next-state and next-output decode; outputs are registered below
    always_comb begin
        state_next_s      = state_r;
        address_next_s    = address;
        rx_enable_next_s  = rx_enable;
        rx_clear_next_s   = 1'b0;
        frame_done_next_s = 1'b0;
        byte_data_next_s  = byte_data;
        byte_valid_next_s = byte_valid;
        byte_last_next_s  = byte_last;
        case (state_r)
            IDLE: begin
                address_next_s   = '0;
                rx_enable_next_s = 1'b1;
                if (full_rise_s && enable) begin
                    state_next_s     = SELECT;
                    rx_enable_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SELECT: begin
                byte_data_next_s  = parallel_in;
                byte_valid_next_s = 1'b1;
                byte_last_next_s  = (address == LAST_ADDR);
                state_next_s      = PRESENT;
            end
            PRESENT: begin
                if (byte_ready) begin
                    byte_valid_next_s = 1'b0;
                    byte_last_next_s  = 1'b0;
                    // Treat any address at or past the end as the last byte so it cannot wrap
                    if (address >= LAST_ADDR) begin
                        state_next_s      = RELEASE;
                        address_next_s    = '0;
                        rx_clear_next_s   = 1'b1;
                        frame_done_next_s = 1'b1;
                    end else begin
                        state_next_s   = SELECT;
                        address_next_s = address + ADDR_W'(1);
                    end
                end else begin
                    state_next_s = PRESENT;
                end
            end
            RELEASE: begin
                rx_enable_next_s = 1'b1;
                state_next_s     = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!full) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_CLR;
                end
            end
            default: begin
                state_next_s      = IDLE;
                address_next_s    = '0;
                rx_enable_next_s  = 1'b1;
                byte_valid_next_s = 1'b0;
                byte_last_next_s  = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address    <= '0;
            rx_enable  <= 1'b1;
            rx_clear   <= 1'b0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            address    <= address_next_s;
            rx_enable  <= rx_enable_next_s;
            rx_clear   <= rx_clear_next_s;
            byte_data  <= byte_data_next_s;
            byte_valid <= byte_valid_next_s;
            byte_last  <= byte_last_next_s;
            frame_done <= frame_done_next_s;
        end
    end

    // Saturating count of frames offered while busy or while readout is disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_count <= 8'h00;
        end else if (full_rise_s && ((state_r != IDLE) || !enable) && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_frame_readout_ctrl.sv
// Randomized bench for frame_readout_ctrl: a frame-level scoreboard predicts the
// byte stream, frame completions and overrun count from the handshake rules.
module tb_frame_readout_ctrl;

    localparam int NB = 12;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          full = 1'b0;
    logic          byte_ready = 1'b0;
    logic [7:0]    parallel_in;
    logic [AW-1:0] address;
    logic          rx_enable, rx_clear, byte_valid, byte_last, frame_done;
    logic [7:0]    byte_data, overrun_count;
    logic [7:0]    mem [16];

    frame_readout_ctrl #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .full(full),
        .parallel_in(parallel_in), .address(address), .rx_enable(rx_enable),
        .rx_clear(rx_clear), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .frame_done(frame_done),
        .overrun_count(overrun_count)
    );

    // Data multiplexer stand-in
    assign parallel_in = mem[address];

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         busy = 1'b0;
    int         idx = 0;
    int         ovr_exp = 0;
    int         frames_done = 0;
    bit         prev_full_m = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         expect_valid_next = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic rise;
        rise = full && !prev_full_m;
        if (expect_valid_next) begin
            check_eq("valid_rise", 32'(byte_valid), 32'd1);
            expect_valid_next = 1'b0;
        end
        if (prev_valid && byte_ready) begin
            check_eq("accept_in_range", 32'(idx < NB), 32'd1);
            check_eq("accept_data", 32'(prev_data), 32'(mem[idx[3:0]]));
            idx++;
            check_eq("valid_gap", 32'(byte_valid), 32'd0);
            if (idx < NB) expect_valid_next = 1'b1;
        end else if (prev_valid) begin
            check_eq("valid_hold", 32'(byte_valid), 32'd1);
            check_eq("data_hold", 32'(byte_data), 32'(prev_data));
        end
        if (rise) begin
            if (!busy && enable) begin
                busy = 1'b1;
                idx = 0;
                expect_valid_next = 1'b1;
                check_eq("select_gap", 32'(byte_valid), 32'd0);
            end else begin
                ovr_exp = (ovr_exp >= 255) ? 255 : ovr_exp + 1;
            end
        end
        check_eq("overrun", 32'(overrun_count), 32'(ovr_exp));
        check_eq("rx_enable", 32'(rx_enable), 32'(!busy));
        check_eq("rx_clear", 32'(rx_clear), 32'(frame_done));
        if (!busy) begin
            check_eq("idle_valid", 32'(byte_valid), 32'd0);
            check_eq("idle_addr", 32'(address), 32'd0);
        end
        if (byte_valid) begin
            check_eq("address", 32'(address), 32'(idx));
            check_eq("byte_last", 32'(byte_last), 32'(idx == NB - 1));
        end else begin
            check_eq("last_low", 32'(byte_last), 32'd0);
        end
        if (frame_done) begin
            check_eq("done_busy", 32'(busy), 32'd1);
            check_eq("done_bytes", 32'(idx), 32'(NB));
            busy = 1'b0;
            frames_done++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (reset) begin
            prev_full_m = 1'b0;
            prev_valid  = 1'b0;
        end else begin
            monitor();
            prev_full_m = full;
            prev_valid  = byte_valid;
            prev_data   = byte_data;
        end
    endtask

    task automatic check_reset();
        check_eq("rst_address", 32'(address), 32'd0);
        check_eq("rst_rx_enable", 32'(rx_enable), 32'd1);
        check_eq("rst_rx_clear", 32'(rx_clear), 32'd0);
        check_eq("rst_byte_data", 32'(byte_data), 32'd0);
        check_eq("rst_byte_valid", 32'(byte_valid), 32'd0);
        check_eq("rst_byte_last", 32'(byte_last), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_overrun", 32'(overrun_count), 32'd0);
    endtask

    // mode 0: always ready; 1: stall 5 cycles on byte 3; 2: random; 3: 300 overrun pulses
    task automatic run_frame(input int mode, input bit en, input int hold);
        int guard, stall, nglitch, start_done;
        bit pending;
        guard = 0; stall = 0; nglitch = 0; pending = 1'b0;
        start_done = frames_done;
        enable = en;
        full = 1'b1;
        byte_ready = (mode == 0 || mode == 1);
        if (!en) begin
            repeat (6) tick();
            full = 1'b0;
            enable = 1'b1;
            repeat (3) tick();
            return;
        end
        while (frames_done == start_done && guard < 2000) begin
            tick();
            guard++;
            case (mode)
                1: begin
                    if (byte_valid && address == 4'd3 && stall < 5) begin
                        byte_ready = 1'b0;
                        stall++;
                    end else begin
                        byte_ready = 1'b1;
                    end
                end
                2: begin
                    byte_ready = 1'($urandom_range(0, 1));
                    enable = 1'($urandom_range(0, 1));
                end
                3: byte_ready = (nglitch >= 300);
                default: byte_ready = 1'b1;
            endcase
            if (pending) begin
                full = 1'b1;
                pending = 1'b0;
                nglitch++;
            end else if (full && byte_valid && !byte_last &&
                         ((mode == 3 && nglitch < 300) || (mode == 2 && $urandom_range(0, 3) == 0))) begin
                full = 1'b0;
                pending = 1'b1;
            end else if (mode == 2 && full && $urandom_range(0, 15) == 0) begin
                full = 1'b0;
            end
        end
        check_eq("frame_complete", 32'(frames_done), 32'(start_done + 1));
        byte_ready = 1'b0;
        enable = 1'b1;
        repeat (hold) tick();
        full = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        repeat (2) @(negedge clock);
        check_reset();
        reset = 1'b0;
        enable = 1'b1;
        repeat (3) tick();

        run_frame(0, 1'b1, 0);
        run_frame(1, 1'b1, 0);
        run_frame(0, 1'b0, 0);
        check_eq("disabled_overrun", 32'(overrun_count), 32'd1);
        run_frame(0, 1'b1, 10);

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
            run_frame(2, ($urandom_range(0, 4) != 0), $urandom_range(0, 4));
        end

        run_frame(3, 1'b1, 0);
        check_eq("ovr_saturated", 32'(overrun_count), 32'd255);

        // Reset in the middle of a frame, then the still-held frame is read from address 0
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        enable = 1'b1;
        full = 1'b1;
        byte_ready = 1'b1;
        for (int g = 0; g < 100 && !(byte_valid && address == 4'd6); g++) tick();
        check_eq("reached_addr6", 32'(address), 32'd6);
        reset = 1'b1;
        #1;
        check_reset();
        busy = 1'b0; idx = 0; ovr_exp = 0; expect_valid_next = 1'b0;
        tick();
        reset = 1'b0;
        run_frame(0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
